// File: rtl/writeback_div_stage_if.sv
// writeback_div_stage_if
//   Bundles the memory-stage inputs and the writeback/divider outputs of
//   writeback_div_stage.
//   master : pipeline side. Drives the *_M signals and observes the
//            writeback and divider results.
//   slave  : writeback_div_stage itself.
//   Memory-stage signals : reg_write_M, mem_to_reg_M, alu_out_M, read_data_M,
//                          write_reg_M, HasDivM, div_signed_M,
//                          div_dividend_M, div_divisor_M
//   Writeback signals    : writeback_value, writeback_id, reg_write_W,
//                          HasDivW, DivHiW, DivLoW, div_busy
interface writeback_div_stage_if #(
    parameter int WIDTH = 32
);
    logic             reg_write_M;
    logic             mem_to_reg_M;
    logic [WIDTH-1:0] alu_out_M;
    logic [WIDTH-1:0] read_data_M;
    logic [4:0]       write_reg_M;
    logic             HasDivM;
    logic             div_signed_M;
    logic [WIDTH-1:0] div_dividend_M;
    logic [WIDTH-1:0] div_divisor_M;

    logic [WIDTH-1:0] writeback_value;
    logic [4:0]       writeback_id;
    logic             reg_write_W;
    logic             HasDivW;
    logic [WIDTH-1:0] DivHiW;
    logic [WIDTH-1:0] DivLoW;
    logic             div_busy;

    modport master (
        output reg_write_M, mem_to_reg_M, alu_out_M, read_data_M, write_reg_M,
               HasDivM, div_signed_M, div_dividend_M, div_divisor_M,
        input  writeback_value, writeback_id, reg_write_W,
               HasDivW, DivHiW, DivLoW, div_busy
    );

    modport slave (
        input  reg_write_M, mem_to_reg_M, alu_out_M, read_data_M, write_reg_M,
               HasDivM, div_signed_M, div_dividend_M, div_divisor_M,
        output writeback_value, writeback_id, reg_write_W,
               HasDivW, DivHiW, DivLoW, div_busy
    );
endinterface

// File: rtl/writeback_div_stage.sv
// writeback_div_stage
//   This module is the writeback-side producer for the register-file write
//   port and for the HI/LO write port.
//   The GPR path is one register stage. It places either the ALU result or
//   the load value on writeback_value. It also forwards writeback_id and
//   reg_write_W.
//   The iterative restoring divider produces one quotient bit per cycle. It
//   returns the remainder on DivHiW and the quotient on DivLoW. HasDivW is a
//   one-cycle strobe that marks a completed divide. div_busy is high while a
//   divide is in flight.
//   Ports:
//     clock : rising-edge clock
//     reset : synchronous, active-high
//     wb    : writeback_div_stage_if.slave (memory-stage in, writeback out)
//   Optional feature:
//     DIV_ZERO_FAST_EN - When this macro is defined, a zero divisor skips the
//                        iterations and goes directly to the sign-fix cycle.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting; a HasDivM here captures operands
//   RUN   | one restoring iteration per cycle, WIDTH iterations
//   FIX   | sign correction, results registered, HasDivW next cycle
module writeback_div_stage #(
    parameter int WIDTH = 32
) (
    input logic                  clock,
    input logic                  reset,
    writeback_div_stage_if.slave wb
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    div_state_t state_q, state_d;

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [IW-1:0]    iter_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             dz_q;

    logic [WIDTH-1:0] wb_value_q;
    logic [4:0]       wb_id_q;
    logic             wb_rw_q;
    logic             has_div_q;
    logic [WIDTH-1:0] div_hi_q;
    logic [WIDTH-1:0] div_lo_q;

    // Operand magnitudes, taken while the divider is IDLE
    logic             dividend_neg, divisor_neg, divisor_zero;
    logic [WIDTH-1:0] dividend_mag, divisor_mag;

    assign dividend_neg = wb.div_signed_M & wb.div_dividend_M[WIDTH-1];
    assign divisor_neg  = wb.div_signed_M & wb.div_divisor_M[WIDTH-1];
    assign divisor_zero = (wb.div_divisor_M == '0);
    assign dividend_mag = dividend_neg ? ('0 - wb.div_dividend_M) : wb.div_dividend_M;
    assign divisor_mag  = divisor_neg  ? ('0 - wb.div_divisor_M)  : wb.div_divisor_M;

    // Restoring step. The compare and subtract are one bit wider than the
    // operands, so the shifted-in bit never overflows.
    logic [WIDTH:0] rem_shift, rem_diff, rem_next;
    logic           rem_ge;
    logic           rem_top_unused;

    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign rem_ge    = (rem_shift >= {1'b0, dvs_q});
    assign rem_diff  = rem_shift - {1'b0, dvs_q};
    assign rem_next  = rem_ge ? rem_diff : rem_shift;
    // The partial remainder is always below the divisor, so its top bit is zero.
    assign rem_top_unused = rem_next[WIDTH];

    // Sign fix. When the divisor is zero, the quotient keeps its all-ones value.
    logic [WIDTH-1:0] fix_lo, fix_hi;

    assign fix_lo = (q_neg_q && !dz_q) ? ('0 - quo_q) : quo_q;
    assign fix_hi = r_neg_q ? ('0 - rem_q) : rem_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wb.HasDivM) begin
`ifdef DIV_ZERO_FAST_EN
                    state_d = divisor_zero ? FIX : RUN;
`else
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                if (iter_q == IW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            iter_q  <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wb.HasDivM) begin
                        dvs_q   <= divisor_mag;
                        iter_q  <= '0;
                        q_neg_q <= dividend_neg ^ divisor_neg;
                        r_neg_q <= dividend_neg;
                        dz_q    <= divisor_zero;
`ifdef DIV_ZERO_FAST_EN
                        if (divisor_zero) begin
                            rem_q <= dividend_mag;
                            quo_q <= '1;
                        end else begin
                            rem_q <= '0;
                            quo_q <= dividend_mag;
                        end
`else
                        rem_q   <= '0;
                        quo_q   <= dividend_mag;
`endif
                    end
                end
                RUN: begin
                    rem_q  <= rem_next[WIDTH-1:0];
                    quo_q  <= {quo_q[WIDTH-2:0], rem_ge};
                    iter_q <= iter_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wb_value_q <= '0;
            wb_id_q    <= '0;
            wb_rw_q    <= 1'b0;
            has_div_q  <= 1'b0;
            div_hi_q   <= '0;
            div_lo_q   <= '0;
        end else begin
            wb_value_q <= wb.mem_to_reg_M ? wb.read_data_M : wb.alu_out_M;
            wb_id_q    <= wb.write_reg_M;
            wb_rw_q    <= wb.reg_write_M;
            has_div_q  <= (state_q == FIX);
            if (state_q == FIX) begin
                div_hi_q <= fix_hi;
                div_lo_q <= fix_lo;
            end
        end
    end

    assign wb.writeback_value = wb_value_q;
    assign wb.writeback_id    = wb_id_q;
    assign wb.reg_write_W     = wb_rw_q;
    assign wb.HasDivW         = has_div_q;
    assign wb.DivHiW          = div_hi_q;
    assign wb.DivLoW          = div_lo_q;
    assign wb.div_busy        = (state_q != IDLE);
endmodule

// File: tb/tb_writeback_div_stage.sv
module tb_writeback_div_stage;
    localparam int WIDTH = 32;
`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST_ZERO = 1'b1;
`else
    localparam bit FAST_ZERO = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    writeback_div_stage_if #(.WIDTH(WIDTH)) wb ();

    writeback_div_stage #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .wb    (wb.slave)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit gpr_rand = 1'b0;

    // Reference model. It tracks the cycle index, the latency of each
    // accepted divide and the arithmetic result.
    int          m_cyc = 0;
    int          m_busy_end = -1;
    int          m_done = -1;
    logic [63:0] m_pend = '0;
    logic [31:0] m_lo = '0, m_hi = '0, exp_val = '0;
    logic [4:0]  exp_id = '0;
    logic        exp_rw = 1'b0, exp_has = 1'b0;

    // Returns {remainder, quotient}.
    function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] n, input logic [31:0] d);
        logic signed [31:0] sn, sd, sq, sr;
        sn = n;
        sd = d;
        if (d == 32'd0)
            return {n, 32'hFFFF_FFFF};
        if (!sg)
            return {n % d, n / d};
        if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF)
            return {32'd0, 32'h8000_0000};
        sq = sn / sd;
        sr = sn % sd;
        return {sr, sq};
    endfunction

    function automatic int div_lat(input logic [31:0] d);
        return (FAST_ZERO && d == 32'd0) ? 2 : WIDTH + 2;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            exp_val    <= '0;
            exp_id     <= '0;
            exp_rw     <= 1'b0;
            exp_has    <= 1'b0;
            m_lo       <= '0;
            m_hi       <= '0;
            m_busy_end <= -1;
            m_done     <= -1;
        end else begin
            exp_val <= wb.mem_to_reg_M ? wb.read_data_M : wb.alu_out_M;
            exp_id  <= wb.write_reg_M;
            exp_rw  <= wb.reg_write_M;
            exp_has <= (m_cyc + 1 == m_done);
            if (m_cyc + 1 == m_done) begin
                m_lo <= m_pend[31:0];
                m_hi <= m_pend[63:32];
            end
            if (wb.HasDivM && m_cyc > m_busy_end) begin
                m_pend     <= ref_div(wb.div_signed_M, wb.div_dividend_M, wb.div_divisor_M);
                m_busy_end <= m_cyc + div_lat(wb.div_divisor_M) - 1;
                m_done     <= m_cyc + div_lat(wb.div_divisor_M);
            end
        end
        m_cyc <= m_cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, m_cyc);
        end
    endtask

    task automatic compare_all();
        chk("writeback_value", wb.writeback_value, exp_val);
        chk("writeback_id", {27'd0, wb.writeback_id}, {27'd0, exp_id});
        chk("reg_write_W", {31'd0, wb.reg_write_W}, {31'd0, exp_rw});
        chk("HasDivW", {31'd0, wb.HasDivW}, {31'd0, exp_has});
        chk("DivLoW", wb.DivLoW, m_lo);
        chk("DivHiW", wb.DivHiW, m_hi);
        chk("div_busy", {31'd0, wb.div_busy}, {31'd0, (m_cyc <= m_busy_end)});
    endtask

    task automatic tick();
        @(negedge clock);
        if (chk_en)
            compare_all();
        if (gpr_rand) begin
            wb.reg_write_M  = 1'($urandom_range(0, 1));
            wb.mem_to_reg_M = 1'($urandom_range(0, 1));
            wb.alu_out_M    = $urandom;
            wb.read_data_M  = $urandom;
            wb.write_reg_M  = 5'($urandom_range(0, 31));
        end
    endtask

    task automatic do_div(input string nm, input logic sg, input logic [31:0] n, input logic [31:0] d,
                          input logic [31:0] elo, input logic [31:0] ehi, input int elat, input int second_at);
        int found = -1;
        int busy_cnt = 0;
        logic [31:0] got_lo = '0, got_hi = '0;
        tick();
        wb.HasDivM        = 1'b1;
        wb.div_signed_M   = sg;
        wb.div_dividend_M = n;
        wb.div_divisor_M  = d;
        for (int k = 1; k <= WIDTH + 10; k++) begin
            tick();
            if (found < 0) begin
                if (wb.HasDivW === 1'b1) begin
                    found  = k;
                    got_lo = wb.DivLoW;
                    got_hi = wb.DivHiW;
                    chk({nm, "_busy_at_strobe"}, {31'd0, wb.div_busy}, 32'd0);
                end else if (wb.div_busy === 1'b1) begin
                    busy_cnt++;
                end
            end
            if (k == second_at) begin
                wb.HasDivM        = 1'b1;
                wb.div_signed_M   = 1'b0;
                wb.div_dividend_M = 32'd50;
                wb.div_divisor_M  = 32'd5;
            end else begin
                wb.HasDivM = 1'b0;
            end
        end
        chk({nm, "_strobe_cycle"}, found, elat);
        chk({nm, "_busy_cycles"}, busy_cnt, elat - 1);
        chk({nm, "_lo"}, got_lo, elo);
        chk({nm, "_hi"}, got_hi, ehi);
    endtask

    initial begin
        int seen;
        wb.reg_write_M    = 1'b0;
        wb.mem_to_reg_M   = 1'b0;
        wb.alu_out_M      = '0;
        wb.read_data_M    = '0;
        wb.write_reg_M    = '0;
        wb.HasDivM        = 1'b0;
        wb.div_signed_M   = 1'b0;
        wb.div_dividend_M = '0;
        wb.div_divisor_M  = '0;
        reset = 1'b1;

        tick();
        chk_en = 1'b1;
        tick();
        chk("reset_value", wb.writeback_value, 32'd0);
        chk("reset_busy", {31'd0, wb.div_busy}, 32'd0);
        chk("reset_has", {31'd0, wb.HasDivW}, 32'd0);
        reset = 1'b0;

        // GPR path
        wb.mem_to_reg_M = 1'b0;
        wb.alu_out_M    = 32'h0000_1234;
        wb.write_reg_M  = 5'd8;
        wb.reg_write_M  = 1'b1;
        tick();
        chk("alu_value", wb.writeback_value, 32'h0000_1234);
        chk("alu_id", {27'd0, wb.writeback_id}, 32'd8);
        chk("alu_rw", {31'd0, wb.reg_write_W}, 32'd1);
        wb.mem_to_reg_M = 1'b1;
        wb.read_data_M  = 32'hDEAD_BEEF;
        tick();
        chk("load_value", wb.writeback_value, 32'hDEAD_BEEF);
        wb.write_reg_M  = 5'd0;
        tick();
        chk("zero_id_rw", {31'd0, wb.reg_write_W}, 32'd1);

        gpr_rand = 1'b1;
        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34, 0);
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, 0);
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 34, 0);
        do_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 34, 0);
        do_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, FAST_ZERO ? 2 : 34, 0);
        do_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, FAST_ZERO ? 2 : 34, 0);
        do_div("divu_1000_10", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 34, 10);

        // Reset in the middle of a divide
        tick();
        wb.HasDivM        = 1'b1;
        wb.div_signed_M   = 1'b0;
        wb.div_dividend_M = 32'd1000;
        wb.div_divisor_M  = 32'd7;
        for (int k = 1; k <= 15; k++) begin
            tick();
            wb.HasDivM = 1'b0;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("midrst_busy", {31'd0, wb.div_busy}, 32'd0);
        chk("midrst_lo", wb.DivLoW, 32'd0);
        chk("midrst_hi", wb.DivHiW, 32'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (wb.HasDivW === 1'b1)
                seen++;
        end
        chk("midrst_no_strobe", seen, 32'd0);
        do_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 34, 0);

        // Random traffic. Overlapping requests and occasional resets are
        // checked against the model every cycle.
        for (int c = 0; c < 2500; c++) begin
            tick();
            reset = ($urandom_range(0, 399) == 0);
            wb.HasDivM      = ($urandom_range(0, 9) == 0);
            wb.div_signed_M = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: begin
                    wb.div_dividend_M = $urandom;
                    wb.div_divisor_M  = 32'd0;
                end
                1: begin
                    wb.div_dividend_M = 32'h8000_0000;
                    wb.div_divisor_M  = 32'hFFFF_FFFF;
                end
                2: begin
                    wb.div_dividend_M = $urandom_range(0, 1000);
                    wb.div_divisor_M  = $urandom_range(1, 20);
                end
                default: begin
                    wb.div_dividend_M = $urandom;
                    wb.div_divisor_M  = $urandom >> $urandom_range(0, 31);
                end
            endcase
        end
        reset      = 1'b0;
        wb.HasDivM = 1'b0;
        for (int c = 0; c < WIDTH + 6; c++)
            tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
